// File: rtl/img_pkg.sv
// Shared types and default geometry for the image output frame scheduler.
package img_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StActive,
        StHblank,
        StDrain,
        StDone
    } img_state_e;

    localparam int unsigned DefWidth      = 768;
    localparam int unsigned DefHeight     = 512;
    localparam int unsigned DefStartDelay = 100;
    localparam int unsigned DefHblank     = 160;

    // Pixel-pair beats in one frame.
    function automatic int unsigned frame_beats(input int unsigned width,
                                                input int unsigned height);
        return (width / 2) * height;
    endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Column, line and linear pixel-pair address counters for one frame.
module img_addr_gen
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned HEIGHT = DefHeight,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned LINE_W = 10,
    parameter int unsigned COL_W  = 9
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [COL_W-1:0]  col_o,
    output logic [LINE_W-1:0] line_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              col_last_o,
    output logic              frame_last_o
);

    localparam logic [COL_W-1:0]  ColLast  = COL_W'(WIDTH / 2 - 1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(frame_beats(WIDTH, HEIGHT) - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign col_last_o   = (col_q == ColLast);
    assign frame_last_o = (addr_q == AddrLast);

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        addr_d = addr_q;
        if (clr_i) begin
            col_d  = '0;
            line_d = '0;
            addr_d = '0;
        end else if (inc_i) begin
            // Wrap to zero after the final beat so the counters rest at 0 between frames.
            if (frame_last_o) begin
                col_d  = '0;
                line_d = '0;
                addr_d = '0;
            end else if (col_last_o) begin
                col_d  = '0;
                line_d = line_q + LINE_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_q  <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            addr_q <= addr_d;
        end
    end

    assign col_o  = col_q;
    assign line_o = line_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/img_frame_sched.sv
// Frame scheduler: paces frame-buffer reads with start delay, line blanking, pause and abort.
module img_frame_sched
    import img_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned HEIGHT      = DefHeight,
    parameter int unsigned START_DELAY = DefStartDelay,
    parameter int unsigned HBLANK      = DefHblank,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned LINE_W      = 10,
    parameter int unsigned COL_W       = 9
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              abort_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              data_write_o,
    output logic [LINE_W-1:0] line_idx_o,
    output logic [COL_W-1:0]  col_idx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int unsigned MaxWait = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
    localparam int unsigned CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
    localparam logic [CntW-1:0] StartCnt  = CntW'(START_DELAY);
    localparam logic [CntW-1:0] HblankCnt = CntW'(HBLANK);

    img_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            data_write_q, data_write_d;
    logic            rd_en, inc, clr;
    logic            col_last, frame_last;

    img_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .clr_i        (clr),
        .inc_i        (inc),
        .col_o        (col_idx_o),
        .line_o       (line_idx_o),
        .addr_o       (rd_addr_o),
        .col_last_o   (col_last),
        .frame_last_o (frame_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    clr = 1'b1;
                    if (START_DELAY == 0) begin
                        state_d = StActive;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = StartCnt;
                    end
                end
            end
            StDelay, StHblank: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StActive: begin
                if (!pause_i) begin
                    rd_en = 1'b1;
                    inc   = 1'b1;
                    if (frame_last) begin
                        state_d = StDrain;
                    end else if (col_last && HBLANK != 0) begin
                        state_d = StHblank;
                        cnt_d   = HblankCnt;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over everything else once a frame is under way.
        if (abort_i && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            clr     = 1'b1;
            inc     = 1'b0;
        end
    end

    // Suppress the beat already in flight when a frame is aborted.
    assign data_write_d = rd_en && !abort_i;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            data_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_write_q <= data_write_d;
        end
    end

    assign rd_en_o      = rd_en;
    assign data_write_o = data_write_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = (state_q == StDone);

endmodule

// File: doc/img_frame_sched.md
Name: img_frame_sched

Overview:
- Frame-level scheduler for the image output path.
- Reads a stored frame from the pixel-pair frame buffer (1-cycle-latency synchronous RAM).
- Generates the per-beat `data_write` strobe that feeds the BMP writer. Each beat carries two pixels (even/odd RGB888).
- Inserts a programmable start delay and inter-line blanking, and supports pause and abort.
- Reports busy and frame-done status to the testbench or top-level controller.

Parameters:
- WIDTH, 768, image width in pixels; must be even.
- HEIGHT, 512, image height in lines.
- START_DELAY, 100, idle cycles between accepted start and first read; 0 allowed.
- HBLANK, 160, idle cycles between the last beat of a line and the first beat of the next; 0 allowed.
- ADDR_W, 18, width of rd_addr; must satisfy 2^ADDR_W >= WIDTH*HEIGHT/2.
- LINE_W, 10, width of line_idx.
- COL_W, 9, width of col_idx.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- pause  in  1  level; while high in ACTIVE, no new reads are issued.
- abort  in  1  single-cycle; terminates the frame and returns to IDLE.
- rd_en  out  1  frame-buffer read enable; one pixel pair per assertion.
- rd_addr  out  ADDR_W  pixel-pair address, valid while rd_en is high.
- data_write  out  1  rd_en delayed one cycle; aligned with RAM read data, which is wired straight to the writer.
- line_idx  out  LINE_W  line of the beat currently issued.
- col_idx  out  COL_W  pair column of the beat currently issued.
- busy  out  1  high from the cycle after start is accepted through the frame_done cycle.
- frame_done  out  1  one-cycle pulse after the last data_write of a completed (non-aborted) frame.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, including mid-frame.
  - Outputs on reset: rd_en=0, rd_addr=0, data_write=0, line_idx=0, col_idx=0, busy=0, frame_done=0; state=IDLE.
- Beat count: N = WIDTH/2 beats per line. Addresses run linearly 0 .. N*HEIGHT-1, top line first, rd_addr = line*N + col.
- States: IDLE, DELAY, ACTIVE, HBLANK, DRAIN, DONE.
  - IDLE: start=1 -> DELAY with counter loaded to START_DELAY. If START_DELAY=0, go directly to ACTIVE.
  - DELAY: counts START_DELAY cycles, then -> ACTIVE. pause is ignored.
  - ACTIVE, pause=0: rd_en=1 with the current address; col increments.
    - At col = N-1, last line: -> DRAIN.
    - At col = N-1, otherwise: -> HBLANK, with col=0 and line+1. If HBLANK=0, stay in ACTIVE (back-to-back lines).
  - ACTIVE, pause=1: rd_en=0; counters and address hold. Resume on the first cycle pause=0.
  - HBLANK: counts HBLANK cycles, then -> ACTIVE. pause is ignored.
  - DRAIN: one cycle, so the final data_write is emitted; -> DONE.
  - DONE: frame_done=1 for one cycle; -> IDLE; busy falls on the following cycle.
- Timing, with start sampled at edge 0 and B = HBLANK:
  - First rd_en at edge START_DELAY.
  - Last rd_en at edge START_DELAY + N*HEIGHT + (HEIGHT-1)*B - 1.
  - frame_done at that edge + 2.
- data_write = rd_en registered; exactly N*HEIGHT pulses per completed frame.
- abort:
  - In any non-IDLE state: next state is IDLE; rd_en and data_write are 0 from the next cycle, so an in-flight data_write is suppressed.
  - Counters clear; no frame_done is issued.
  - abort has priority over start in the same cycle. abort in IDLE has no effect.
- start while not IDLE: ignored, no queuing.
- Counters use exact widths; no wrap-around can occur within a frame when parameters satisfy their width constraints.

Decomposition:
- Package img_pkg holds:
  - the state enum;
  - default geometry constants (768, 512, 100, 160);
  - a function computing N*HEIGHT.
- Sub-module img_addr_gen: col/line/address counters with load, increment, hold and clear; the FSM drives it.

Test Plan (WIDTH=8, HEIGHT=4, START_DELAY=3, HBLANK=2 unless stated):
- Nominal frame:
  - Stimulus: start at edge 0.
  - Response: rd_en high at edges 3-6, 9-12, 15-18, 21-24; addresses 0..15; data_write one cycle behind each rd_en; frame_done at edge 26; busy low again at edge 27.
- Pause:
  - Stimulus: nominal frame, with pause high for 3 cycles covering edges 4-6.
  - Response: rd_addr holds at 1; the remaining beats shift by 3; frame_done at edge 29; still 16 data_write pulses.
- Abort:
  - Stimulus: abort at edge 10 (line 1 active).
  - Response: data_write 0 from edge 11; state IDLE; no frame_done.
  - Follow-up: a new start then produces a full 16-beat frame beginning at address 0.
- Zero gaps:
  - Stimulus: START_DELAY=0, HBLANK=0.
  - Response: rd_en continuous from edge 0 to edge 15; frame_done at edge 17.
- Start/abort/reset corner cases:
  - start asserted mid-frame: ignored.
  - start and abort in the same IDLE cycle: no frame starts.
  - HRESETn low mid-frame: all outputs 0 immediately, without waiting for a clock edge.
- Full size (defaults):
  - Response: exactly 196608 data_write pulses; last rd_addr = 196607; frame_done once.
